// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, states, datapath select codes.
// Build macro CTRL_JAL_EN enables jal decoding; without it jal falls through as a NOP.
package multi_cycle_ctrl_pkg;

  localparam logic [5:0] OpAdd   = 6'b000000;
  localparam logic [5:0] OpSub   = 6'b000001;
  localparam logic [5:0] OpAddiu = 6'b000010;
  localparam logic [5:0] OpAnd   = 6'b010000;
  localparam logic [5:0] OpAndi  = 6'b010001;
  localparam logic [5:0] OpOri   = 6'b010010;
  localparam logic [5:0] OpSlt   = 6'b100110;
  localparam logic [5:0] OpSlti  = 6'b100111;
  localparam logic [5:0] OpSw    = 6'b110000;
  localparam logic [5:0] OpLw    = 6'b110001;
  localparam logic [5:0] OpBeq   = 6'b110100;
  localparam logic [5:0] OpBne   = 6'b110101;
  localparam logic [5:0] OpBltz  = 6'b110110;
  localparam logic [5:0] OpJ     = 6'b111000;
  localparam logic [5:0] OpJr    = 6'b111001;
  localparam logic [5:0] OpJal   = 6'b111010;
  localparam logic [5:0] OpHalt  = 6'b111111;

  typedef enum logic [3:0] {
    StIf    = 4'd0,
    StId    = 4'd1,
    StExeAl = 4'd2,
    StWbAl  = 4'd3,
    StExeBr = 4'd4,
    StExeLs = 4'd5,
    StMem   = 4'd6,
    StWbLd  = 4'd7,
    StHalt  = 4'd8
  } state_e;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b100;

  localparam logic [1:0] PcSrcInc    = 2'b00;
  localparam logic [1:0] PcSrcBranch = 2'b01;
  localparam logic [1:0] PcSrcReg    = 2'b10;
  localparam logic [1:0] PcSrcJump   = 2'b11;

  localparam logic [1:0] RegDstRa = 2'b00;
  localparam logic [1:0] RegDstRt = 2'b01;
  localparam logic [1:0] RegDstRd = 2'b10;

  typedef enum logic [2:0] {
    OcNop, OcJump, OcAlu, OcBranch, OcMem, OcHalt
  } op_class_e;

  function automatic op_class_e op_class(input logic [5:0] op);
    op_class_e c;
    case (op)
      OpJ, OpJr: c = OcJump;
`ifdef CTRL_JAL_EN
      OpJal: c = OcJump;
`endif
      OpAdd, OpSub, OpAddiu, OpAnd, OpAndi, OpOri, OpSlt, OpSlti: c = OcAlu;
      OpBeq, OpBne, OpBltz: c = OcBranch;
      OpSw, OpLw: c = OcMem;
      OpHalt: c = OcHalt;
      default: c = OcNop;
    endcase
    return c;
  endfunction

  function automatic logic is_rtype(input logic [5:0] op);
    return (op == OpAdd) || (op == OpSub) || (op == OpAnd) || (op == OpSlt);
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Opcode/flag inputs and control outputs exchanged between datapath and controller.
interface multi_cycle_ctrl_if;
  logic [5:0]  op;
  logic        zero;
  logic        sign;
  logic        PCWre;
  logic        IRWre;
  logic        RegWre;
  logic        mRD;
  logic        mWR;
  logic        ALUSrcA;
  logic        ALUSrcB;
  logic        ExtSel;
  logic        DBDataSrc;
  logic        WrRegDSrc;
  logic [1:0]  RegDst;
  logic [1:0]  PCSrc;
  logic [2:0]  ALUOp;
  logic [3:0]  state;
  logic [31:0] inst_count;

  // Datapath side.
  modport master (
    output op, zero, sign,
    input  PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc,
    input  RegDst, PCSrc, ALUOp, state, inst_count
  );

  // Controller side.
  modport slave (
    input  op, zero, sign,
    output PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc,
    output RegDst, PCSrc, ALUOp, state, inst_count
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational control decode from current state, opcode and ALU flags.
module ctrl_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic [5:0] i_op,
  input  logic       i_zero,
  input  logic       i_sign,
  input  logic       i_reset,
  output logic       o_pc_wre,
  output logic       o_ir_wre,
  output logic       o_reg_wre,
  output logic       o_m_rd,
  output logic       o_m_wr,
  output logic       o_alu_src_a,
  output logic       o_alu_src_b,
  output logic       o_ext_sel,
  output logic       o_db_data_src,
  output logic       o_wr_reg_d_src,
  output logic [1:0] o_reg_dst,
  output logic [1:0] o_pc_src,
  output logic [2:0] o_alu_op
);

  op_class_e w_class;
  logic      w_taken;

  assign w_class = op_class(i_op);
  assign w_taken = ((i_op == OpBeq) && i_zero) || ((i_op == OpBne) && !i_zero) ||
                   ((i_op == OpBltz) && i_sign);

  always_comb begin
    o_pc_wre       = 1'b0;
    o_ir_wre       = 1'b0;
    o_reg_wre      = 1'b0;
    o_m_rd         = 1'b0;
    o_m_wr         = 1'b0;
    o_alu_src_a    = 1'b0;
    o_alu_src_b    = 1'b0;
    o_ext_sel      = 1'b1;
    o_db_data_src  = 1'b0;
    o_wr_reg_d_src = 1'b1;
    o_reg_dst      = RegDstRt;
    o_pc_src       = PcSrcInc;
    o_alu_op       = AluAdd;

    // The opcode is not yet valid in IF, so op-derived selects stay at defaults there.
    if (i_state != StIf) begin
      o_alu_src_b = (i_op == OpAddiu) || (i_op == OpAndi) || (i_op == OpOri) ||
                    (i_op == OpSlti) || (i_op == OpLw) || (i_op == OpSw);
      o_ext_sel   = !((i_op == OpAndi) || (i_op == OpOri));
      o_reg_dst   = is_rtype(i_op) ? RegDstRd : RegDstRt;
      case (i_op)
        OpSub, OpBeq, OpBne, OpBltz: o_alu_op = AluSub;
        OpAnd, OpAndi:               o_alu_op = AluAnd;
        OpOri:                       o_alu_op = AluOr;
        OpSlt, OpSlti:               o_alu_op = AluSlt;
        default:                     o_alu_op = AluAdd;
      endcase
    end

    unique case (i_state)
      StIf: o_ir_wre = 1'b1;
      StId: begin
        if (w_class == OcNop) begin
          o_pc_wre = 1'b1;
        end else if (w_class == OcJump) begin
          o_pc_wre = 1'b1;
          o_pc_src = (i_op == OpJr) ? PcSrcReg : PcSrcJump;
          // Only reachable for jal when the jump class includes it.
          if (i_op == OpJal) begin
            o_reg_wre      = 1'b1;
            o_reg_dst      = RegDstRa;
            o_wr_reg_d_src = 1'b0;
          end
        end
      end
      StWbAl: begin
        o_reg_wre = 1'b1;
        o_pc_wre  = 1'b1;
      end
      StExeBr: begin
        o_pc_wre = 1'b1;
        o_pc_src = w_taken ? PcSrcBranch : PcSrcInc;
      end
      StMem: begin
        o_m_rd   = (i_op == OpLw);
        o_m_wr   = (i_op == OpSw);
        o_pc_wre = (i_op != OpLw);
      end
      StWbLd: begin
        o_reg_wre     = 1'b1;
        o_db_data_src = 1'b1;
        o_reg_dst     = RegDstRt;
        o_pc_wre      = 1'b1;
      end
      default: ;
    endcase

    if (i_reset) begin
      o_pc_wre  = 1'b0;
      o_ir_wre  = 1'b0;
      o_reg_wre = 1'b0;
      o_m_rd    = 1'b0;
      o_m_wr    = 1'b0;
    end
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU controller: state register and retired-instruction counter around ctrl_decode.
// jal support is selected at build time with CTRL_JAL_EN.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
(
  input logic          CLK,
  input logic          Reset,
  multi_cycle_ctrl_if.slave bus
);

  state_e      r_state;
  logic [31:0] r_inst_count;
  logic        w_pc_wre;

  ctrl_decode u_decode (
    .i_state        (r_state),
    .i_op           (bus.op),
    .i_zero         (bus.zero),
    .i_sign         (bus.sign),
    .i_reset        (Reset),
    .o_pc_wre       (w_pc_wre),
    .o_ir_wre       (bus.IRWre),
    .o_reg_wre      (bus.RegWre),
    .o_m_rd         (bus.mRD),
    .o_m_wr         (bus.mWR),
    .o_alu_src_a    (bus.ALUSrcA),
    .o_alu_src_b    (bus.ALUSrcB),
    .o_ext_sel      (bus.ExtSel),
    .o_db_data_src  (bus.DBDataSrc),
    .o_wr_reg_d_src (bus.WrRegDSrc),
    .o_reg_dst      (bus.RegDst),
    .o_pc_src       (bus.PCSrc),
    .o_alu_op       (bus.ALUOp)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state      <= StIf;
      r_inst_count <= 32'd0;
    end else begin
      // PCWre marks the final cycle of an instruction, so it doubles as the retire strobe.
      if (w_pc_wre) begin
        r_inst_count <= r_inst_count + 32'd1;
      end
      case (r_state)
        StIf: r_state <= StId;
        StId: begin
          case (op_class(bus.op))
            OcAlu:    r_state <= StExeAl;
            OcBranch: r_state <= StExeBr;
            OcMem:    r_state <= StExeLs;
            OcHalt:   r_state <= StHalt;
            default:  r_state <= StIf;
          endcase
        end
        StExeAl: r_state <= StWbAl;
        StWbAl:  r_state <= StIf;
        StExeBr: r_state <= StIf;
        StExeLs: r_state <= StMem;
        StMem:   r_state <= (bus.op == OpLw) ? StWbLd : StIf;
        StWbLd:  r_state <= StIf;
        StHalt:  r_state <= StHalt;
        default: r_state <= StIf;
      endcase
    end
  end

  assign bus.PCWre      = w_pc_wre;
  assign bus.state      = r_state;
  assign bus.inst_count = r_inst_count;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: per-cycle expectations from an instruction-level model.
module tb_multi_cycle_ctrl;
  import multi_cycle_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic Reset = 1'b1;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  localparam bit JalEn =
`ifdef CTRL_JAL_EN
    1'b1;
`else
    1'b0;
`endif

  typedef enum {KJmp, KNop, KAluR, KAluI, KBr, KSw, KLw} kind_e;

  typedef struct {
    logic        chk_state;
    logic [3:0]  state;
    logic        pcwre, irwre, regwre, mrd, mwr;
    logic        chk_pcsrc;
    logic [1:0]  pcsrc;
    logic        chk_regdst;
    logic [1:0]  regdst;
    logic        chk_wrd;
    logic        wrd;
    logic        chk_dbd;
    logic        dbd;
    logic        chk_ext;
    logic        alusrcb, extsel;
    logic        chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] m_count = 32'd0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  function automatic kind_e kind_of(logic [5:0] o);
    case (o)
      OpJ, OpJr:                        return KJmp;
      OpJal:                            return JalEn ? KJmp : KNop;
      OpAdd, OpSub, OpAnd, OpSlt:       return KAluR;
      OpAddiu, OpAndi, OpOri, OpSlti:   return KAluI;
      OpBeq, OpBne, OpBltz:             return KBr;
      OpSw:                             return KSw;
      OpLw:                             return KLw;
      default:                          return KNop;
    endcase
  endfunction

  task automatic step(input logic [5:0] o, input logic z, input logic s, input logic r,
                      input exp_t e);
    bus.op   = o;
    bus.zero = z;
    bus.sign = s;
    Reset    = r;
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, derived from its class and latency.
  task automatic run_instr(input logic [5:0] o, input logic z, input logic s);
    kind_e    k;
    state_e   seq[$];
    logic     taken;
    exp_t     e;
    logic     last;
    k = kind_of(o);
    seq = '{StIf, StId};
    if (k == KAluR || k == KAluI) begin
      seq.push_back(StExeAl);
      seq.push_back(StWbAl);
    end else if (k == KBr) begin
      seq.push_back(StExeBr);
    end else if (k == KSw || k == KLw) begin
      seq.push_back(StExeLs);
      seq.push_back(StMem);
      if (k == KLw) seq.push_back(StWbLd);
    end
    taken = ((o == OpBeq) && z) || ((o == OpBne) && !z) || ((o == OpBltz) && s);
    for (int i = 0; i < seq.size(); i++) begin
      last        = (i == seq.size() - 1);
      e           = blank();
      e.chk_state = 1'b1;
      e.state     = seq[i];
      e.irwre     = (i == 0);
      e.pcwre     = last;
      e.regwre    = (last && (k == KAluR || k == KAluI || k == KLw)) ||
                    (i == 1 && k == KJmp && o == OpJal);
      e.mrd       = (k == KLw) && (i == 3);
      e.mwr       = (k == KSw) && (i == 3);
      if (last) begin
        e.chk_pcsrc = 1'b1;
        if (k == KJmp)               e.pcsrc = (o == OpJr) ? 2'b10 : 2'b11;
        else if (k == KBr && taken)  e.pcsrc = 2'b01;
        else                         e.pcsrc = 2'b00;
      end
      if (e.regwre) begin
        e.chk_regdst = 1'b1;
        e.regdst     = (k == KAluR) ? 2'b10 : ((k == KJmp) ? 2'b00 : 2'b01);
        e.chk_wrd    = 1'b1;
        e.wrd        = (k != KJmp);
      end
      e.chk_dbd = 1'b1;
      e.dbd     = (k == KLw) && (i == 4);
      if (i == 2 && (k == KAluR || k == KAluI || k == KSw || k == KLw)) begin
        e.chk_ext = 1'b1;
        e.alusrcb = (k != KAluR);
        e.extsel  = !((o == OpAndi) || (o == OpOri));
      end
      e.chk_cnt = 1'b1;
      e.cnt     = m_count;
      // The opcode is only meaningful from ID onward; garbage in IF must not matter.
      step((i == 0) ? 6'($urandom) : o, z, s, 1'b0, e);
      if (last) m_count = m_count + 32'd1;
    end
  endtask

  // Monitor: pops one expectation per cycle and compares against the DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_state) chk("state", 32'(bus.state), 32'(e.state));
        chk("PCWre", 32'(bus.PCWre), 32'(e.pcwre));
        chk("IRWre", 32'(bus.IRWre), 32'(e.irwre));
        chk("RegWre", 32'(bus.RegWre), 32'(e.regwre));
        chk("mRD", 32'(bus.mRD), 32'(e.mrd));
        chk("mWR", 32'(bus.mWR), 32'(e.mwr));
        if (e.chk_pcsrc)  chk("PCSrc", 32'(bus.PCSrc), 32'(e.pcsrc));
        if (e.chk_regdst) chk("RegDst", 32'(bus.RegDst), 32'(e.regdst));
        if (e.chk_wrd)    chk("WrRegDSrc", 32'(bus.WrRegDSrc), 32'(e.wrd));
        if (e.chk_dbd)    chk("DBDataSrc", 32'(bus.DBDataSrc), 32'(e.dbd));
        if (e.chk_ext) begin
          chk("ALUSrcB", 32'(bus.ALUSrcB), 32'(e.alusrcb));
          chk("ExtSel", 32'(bus.ExtSel), 32'(e.extsel));
        end
        if (e.chk_cnt)    chk("inst_count", bus.inst_count, e.cnt);
        cyc++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops[$];
    exp_t       e;
    ops = '{OpAdd, OpSub, OpAddiu, OpAnd, OpAndi, OpOri, OpSlt, OpSlti, OpSw, OpLw,
            OpBeq, OpBne, OpBltz, OpJ, OpJr, OpJal, 6'b000011, 6'b101010};
    bus.op   = 6'd0;
    bus.zero = 1'b0;
    bus.sign = 1'b0;
    @(posedge CLK);
    #1;

    // Reset cycle: enables held low.
    e = blank();
    step(6'd0, 1'b0, 1'b0, 1'b1, e);
    m_count = 32'd0;

    // Directed instructions first, then random mix.
    run_instr(OpAdd, 1'b0, 1'b0);
    run_instr(OpLw, 1'b0, 1'b0);
    run_instr(OpBeq, 1'b1, 1'b0);
    run_instr(OpBeq, 1'b0, 1'b0);
    run_instr(OpJal, 1'b0, 1'b0);
    run_instr(OpSw, 1'b0, 1'b0);
    run_instr(6'b000011, 1'b0, 1'b0);
    for (int n = 0; n < 60; n++) begin
      run_instr(ops[$urandom_range(0, ops.size() - 1)], 1'($urandom), 1'($urandom));
    end

    // halt: held for 10 cycles with no retirement.
    e = blank(); e.chk_state = 1'b1; e.state = StIf; e.irwre = 1'b1;
    e.chk_cnt = 1'b1; e.cnt = m_count;
    step(OpHalt, 1'b0, 1'b0, 1'b0, e);
    e = blank(); e.chk_state = 1'b1; e.state = StId; e.chk_cnt = 1'b1; e.cnt = m_count;
    step(OpHalt, 1'b0, 1'b0, 1'b0, e);
    for (int i = 0; i < 10; i++) begin
      e = blank(); e.chk_state = 1'b1; e.state = StHalt; e.chk_cnt = 1'b1; e.cnt = m_count;
      step(OpHalt, 1'($urandom), 1'($urandom), 1'b0, e);
    end
    e = blank(); e.chk_state = 1'b1; e.state = StHalt; e.chk_cnt = 1'b1; e.cnt = m_count;
    step(OpHalt, 1'b0, 1'b0, 1'b1, e);
    m_count = 32'd0;

    // sw interrupted by reset in MEM: no write, restart from IF with count 0.
    e = blank(); e.chk_state = 1'b1; e.state = StIf; e.irwre = 1'b1;
    e.chk_cnt = 1'b1; e.cnt = 32'd0;
    step(OpSw, 1'b0, 1'b0, 1'b0, e);
    e = blank(); e.chk_state = 1'b1; e.state = StId; e.chk_cnt = 1'b1; e.cnt = 32'd0;
    step(OpSw, 1'b0, 1'b0, 1'b0, e);
    e = blank(); e.chk_state = 1'b1; e.state = StExeLs; e.chk_cnt = 1'b1; e.cnt = 32'd0;
    step(OpSw, 1'b0, 1'b0, 1'b0, e);
    e = blank(); e.chk_state = 1'b1; e.state = StMem; e.chk_cnt = 1'b1; e.cnt = 32'd0;
    step(OpSw, 1'b0, 1'b0, 1'b1, e);
    m_count = 32'd0;
    run_instr(OpAdd, 1'b0, 1'b0);
    run_instr(OpBltz, 1'b0, 1'b1);

    @(negedge CLK);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high; ports named CLK and Reset.
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 op  in  6  opcode from instruction register; stable from ID onward.
REQ-005 zero  in  1  ALU result equals zero; sign  in  1  ALU result negative.
REQ-006 PCWre, IRWre, RegWre, mRD, mWR  out  1 each  PC, IR, register-file and data-memory read/write enables.
REQ-007 ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc  out  1 each  datapath mux and extend selects.
REQ-008 RegDst  out  2  write-register select: 00=$31, 01=rt, 10=rd; drives the 3:1 5-bit register-address mux.
REQ-009 PCSrc  out  2  next PC: 00=PC+4, 01=branch target, 10=rs (jr), 11=jump target.
REQ-010 ALUOp  out  3  ALU function code.
REQ-011 state  out  4  current state, for debug; inst_count  out  32  retired-instruction count.

Function
REQ-012 SHALL hold a 4-bit state register with states IF, ID, EXE_AL, WB_AL, EXE_BR, EXE_LS, MEM, WB_LD, HALT.
REQ-013 IF->ID unconditionally; IRWre=1 only in IF.
REQ-014 From ID: j, jr, jal -> IF; add/sub/addiu/and/andi/ori/slt/slti -> EXE_AL; beq/bne/bltz -> EXE_BR; lw/sw -> EXE_LS; halt -> HALT; any other opcode -> IF (NOP).
REQ-015 EXE_AL->WB_AL->IF; EXE_BR->IF; EXE_LS->MEM; MEM->WB_LD for lw, MEM->IF for sw; WB_LD->IF; HALT->HALT until Reset.
REQ-016 PCWre=1 only in the last cycle of each instruction (the cycle whose next state is IF); never in HALT.
REQ-017 inst_count SHALL increment by 1 on each clock edge where PCWre=1; wraps from 0xFFFFFFFF to 0.
REQ-018 Latencies in cycles: j/jr/jal/NOP 2, branch 3, R/I arithmetic 4, sw 4, lw 5.
REQ-019 RegWre=1 only in WB_AL, WB_LD, and ID for jal; RegDst: 10 for R-type, 01 for I-type and lw, 00 for jal.
REQ-020 WrRegDSrc=0 only for jal (writes PC+4); else 1.
REQ-021 mRD=1 only in MEM for lw; mWR=1 only in MEM for sw; never both.
REQ-022 Branch taken: beq when zero=1, bne when zero=0, bltz when sign=1; PCSrc=01 in EXE_BR when taken, else 00.
REQ-023 ALUSrcB=1 for addiu/andi/ori/slti/lw/sw; ExtSel=0 for andi/ori, else 1; DBDataSrc=1 only in WB_LD.
REQ-024 Outputs SHALL be combinational functions of state, op, zero and sign; no output depends on op while in IF.

Reset
REQ-025 On a clock edge with Reset=1: state<=IF, inst_count<=0, from any state including HALT and mid-instruction.
REQ-026 While Reset=1, PCWre, IRWre, RegWre, mRD and mWR SHALL be forced to 0; other outputs are don't-care.

Configuration
REQ-027 Macro CTRL_JAL_EN: defined -> jal decoded per REQ-014/019/020; undefined -> jal opcode treated as NOP (2 cycles, RegWre=0, PCSrc=00).

Structure
REQ-028 Shared package SHALL hold opcode constants (add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, slt 100110, slti 100111, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111), state encodings, ALUOp, PCSrc and RegDst codes.
REQ-029 One sub-module ctrl_decode (combinational output decode); state register and inst_count stay in the top.

Verification
REQ-030 Reset then op=add -> states IF,ID,EXE_AL,WB_AL; WB_AL: RegWre=1, RegDst=10, PCWre=1; inst_count=1.
REQ-031 op=lw -> 5 cycles; MEM: mRD=1, mWR=0; WB_LD: RegDst=01, DBDataSrc=1, RegWre=1.
REQ-032 op=beq, zero=1 -> EXE_BR PCSrc=01; zero=0 -> PCSrc=00; both 3 cycles, PCWre=1 in EXE_BR.
REQ-033 op=jal with CTRL_JAL_EN -> ID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11; without it -> RegWre=0, PCSrc=00.
REQ-034 op=halt -> HALT held 10 cycles, PCWre=0, inst_count unchanged; Reset=1 one cycle -> state=IF, inst_count=0.
REQ-035 Reset asserted in MEM of sw -> mWR=0 that cycle, next state IF.
